// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed driver for NUM_DIGITS common-select seven-segment
// digits. Provides hex decode, per-digit blank and decimal point, leading-zero
// suppression, PWM brightness with an anti-ghost dead time at each slot start,
// and a double-buffered (shadow -> display) register so the visible digits
// only change on a frame boundary. Every output pin comes straight from a flop.
module seven_seg_scan #(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_LOG2      = 16,
  parameter int BRIGHT_W       = 4,
  parameter int DEAD_CYCLES    = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [6*NUM_DIGITS-1:0]   digits_in,
  input  logic                      load,
  input  logic                      lz_en,
  input  logic [BRIGHT_W-1:0]       brightness,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     sel,
  output logic                      frame_tick
);

  // Slot counter must hold 0..NUM_DIGITS-1.
  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SCAN_LOG2-1:0] PRE_MAX   = '1;
  localparam logic [SCAN_LOG2-1:0] DEAD_END  = SCAN_LOG2'(DEAD_CYCLES);
  localparam logic [SLOT_W-1:0]    SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

  // A blank digit has only its blank bit (bit 5) set.
  localparam logic [5:0]              BLANK_DIGIT = 6'b100000;
  localparam logic [6*NUM_DIGITS-1:0] BLANK_ALL   = {NUM_DIGITS{BLANK_DIGIT}};

  // Pin levels that mean "off" for the chosen polarity.
  localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW ? 1'b1  : 1'b0;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                             : {NUM_DIGITS{1'b0}};

  // Hex value to active-high gfedcba pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SCAN_LOG2-1:0]    pre_cnt_q,    pre_cnt_d;
  logic [SLOT_W-1:0]       slot_q,       slot_d;
  logic [6*NUM_DIGITS-1:0] shadow_q,     shadow_d;
  logic [6*NUM_DIGITS-1:0] display_q,    display_d;
  logic [6:0]              seg_q,        seg_d;
  logic                    dp_q,         dp_d;
  logic [NUM_DIGITS-1:0]   sel_q,        sel_d;
  logic                    frame_tick_q, frame_tick_d;

  logic pre_wrap;
  logic frame_start;

  // ---------------------------------------------------------------------------
  // Per-digit decode and zero detection from the display buffer
  // ---------------------------------------------------------------------------
  logic [6:0]            digit_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] digit_dp;
  logic [NUM_DIGITS-1:0] digit_blank;
  logic [NUM_DIGITS-1:0] digit_zero;
  logic [NUM_DIGITS-1:0] zero_from;
  logic [NUM_DIGITS-1:0] suppress;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_seg[gi]   = hex_to_seg(display_q[6*gi +: 4]);
      assign digit_dp[gi]    = display_q[6*gi + 4];
      assign digit_blank[gi] = display_q[6*gi + 5];
      // "Zero" for suppression purposes means value 0 and no decimal point.
      assign digit_zero[gi]  = (display_q[6*gi +: 4] == 4'd0) && !display_q[6*gi + 4];
    end
  endgenerate

  // zero_from[k]: digit k and every more-significant digit are zero.
  // Digit 0 is never suppressed so a value of zero still shows a single "0".
  always_comb begin
    logic acc;
    zero_from = '0;
    suppress  = '0;
    acc       = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc          = acc & digit_zero[i];
      zero_from[i] = acc;
    end
    for (int i = 1; i < NUM_DIGITS; i++) begin
      suppress[i] = lz_en & zero_from[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler, slot sequencing and double buffering
  // ---------------------------------------------------------------------------
  // Next-state for the scan counters, the buffers and the frame pulse.
  always_comb begin
    pre_cnt_d    = pre_cnt_q + 1'b1;
    slot_d       = slot_q;
    pre_wrap     = (pre_cnt_q == PRE_MAX);
    frame_start  = pre_wrap && (slot_q == SLOT_LAST);
    shadow_d     = shadow_q;
    display_d    = display_q;
    frame_tick_d = 1'b0;

    if (pre_wrap) begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end

    // The display takes the shadow contents as they were before this edge,
    // so a load on the same edge only becomes visible one frame later.
    if (frame_start) begin
      display_d    = shadow_q;
      frame_tick_d = 1'b1;
    end

    if (load) begin
      shadow_d = digits_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Pin drive for the current slot
  // ---------------------------------------------------------------------------
  logic                  en;
  logic                  lit;
  logic [6:0]            cur_seg;
  logic                  cur_dp;
  logic                  cur_hidden;
  logic [NUM_DIGITS-1:0] sel_onehot;

  // Select the digit addressed by the slot and compute the registered pin levels.
  // When the select is off the segments are forced off too, so segment edges
  // never land while a digit is enabled.
  always_comb begin
    cur_seg    = '0;
    cur_dp     = 1'b0;
    cur_hidden = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        cur_seg    = digit_seg[i];
        cur_dp     = digit_dp[i];
        cur_hidden = digit_blank[i] | suppress[i];
      end
    end

    en = (pre_cnt_q >= DEAD_END) &&
         (pre_cnt_q[SCAN_LOG2-1 -: BRIGHT_W] < brightness);
    lit        = en && !cur_hidden;
    sel_onehot = NUM_DIGITS'(1) << slot_q;

    sel_d = SEL_OFF;
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    if (en) begin
      sel_d = SEL_ACTIVE_LOW ? ~sel_onehot : sel_onehot;
    end
    if (lit) begin
      seg_d = SEG_ACTIVE_LOW ? ~cur_seg : cur_seg;
      dp_d  = SEG_ACTIVE_LOW ? ~cur_dp  : cur_dp;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // All state and output flops; reset blanks everything and restarts the scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q    <= '0;
      slot_q       <= '0;
      shadow_q     <= BLANK_ALL;
      display_q    <= BLANK_ALL;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      sel_q        <= SEL_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      sel_q        <= sel_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign sel        = sel_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Testbench for seven_seg_scan (6 digits, 32-cycle slots, 2-bit brightness,
// 2 dead cycles, active-low pins). Expected pin values come from a cycle
// model derived from elapsed-time arithmetic and the digit rules.
module tb_seven_seg_scan;

  localparam int N        = 6;
  localparam int SL       = 5;
  localparam int BW       = 2;
  localparam int DC       = 2;
  localparam int SLOT_LEN = 1 << SL;
  localparam int FRAME    = N * SLOT_LEN;
  localparam int STEP     = SLOT_LEN >> BW;  // cycles per brightness step

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [6*N-1:0] digits_in = '0;
  logic           load = 1'b0;
  logic           lz_en = 1'b0;
  logic [BW-1:0]  brightness = '0;
  logic [6:0]     seg;
  logic           dp;
  logic [N-1:0]   sel;
  logic           frame_tick;

  always #5 clk = ~clk;

  seven_seg_scan #(
    .NUM_DIGITS    (N),
    .SCAN_LOG2     (SL),
    .BRIGHT_W      (BW),
    .DEAD_CYCLES   (DC),
    .SEG_ACTIVE_LOW(1'b1),
    .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits_in (digits_in),
    .load      (load),
    .lz_en     (lz_en),
    .brightness(brightness),
    .seg       (seg),
    .dp        (dp),
    .sel       (sel),
    .frame_tick(frame_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: cycles since reset release, shadow and display.
  int             n_m = 0;
  logic [6*N-1:0] shadow_m;
  logic [6*N-1:0] disp_m;
  logic [6:0]     exp_seg;
  logic           exp_dp;
  logic [N-1:0]   exp_sel;
  logic           exp_tick;

  logic [6:0] hex_font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t cyc=%0d: got %0h expected %0h", tag, $time, n_m, got, exp);
    end
  endtask

  function automatic logic [6*N-1:0] all_blank();
    logic [6*N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[6*i+5] = 1'b1;
    return r;
  endfunction

  function automatic logic [5:0] dg(input int v, input bit dpb, input bit blank);
    logic [3:0] v4;
    v4 = v[3:0];
    return {blank, dpb, v4};
  endfunction

  function automatic logic [5:0] rand_digit();
    int v;
    v = ($urandom % 3 == 0) ? 0 : int'($urandom % 16);
    return dg(v, ($urandom % 4) == 0, ($urandom % 8) == 0);
  endfunction

  // Compute pins expected after the coming edge from the current inputs,
  // then advance the model across that edge.
  task automatic predict();
    int   pre, slot, v;
    bit   en, dpb, hidden, zero_above;
    if (rst) begin
      exp_seg  = 7'h7F;
      exp_dp   = 1'b1;
      exp_sel  = '1;
      exp_tick = 1'b0;
      n_m      = 0;
      shadow_m = all_blank();
      disp_m   = all_blank();
    end else begin
      pre  = n_m % SLOT_LEN;
      slot = (n_m / SLOT_LEN) % N;
      en   = (pre >= DC) && ((pre / STEP) < int'(brightness));
      v    = int'(disp_m[6*slot +: 4]);
      dpb  = disp_m[6*slot + 4];
      zero_above = 1'b1;
      for (int j = slot; j < N; j++) begin
        if (disp_m[6*j +: 4] != 4'd0 || disp_m[6*j + 4]) zero_above = 1'b0;
      end
      hidden  = disp_m[6*slot + 5] || (lz_en && slot != 0 && zero_above);
      exp_sel = en ? ~(N'(1) << slot) : '1;
      exp_seg = (en && !hidden) ? ~hex_font[v] : 7'h7F;
      exp_dp  = (en && !hidden) ? ~dpb : 1'b1;
      n_m++;
      exp_tick = (n_m % FRAME) == 0;
      if (exp_tick) disp_m = shadow_m;
      if (load) shadow_m = digits_in;
    end
  endtask

  task automatic cycle();
    predict();
    @(posedge clk);
    @(negedge clk);
    check("seg",        64'(seg),        64'(exp_seg));
    check("dp",         64'(dp),         64'(exp_dp));
    check("sel",        64'(sel),        64'(exp_sel));
    check("frame_tick", 64'(frame_tick), 64'(exp_tick));
  endtask

  task automatic run(input int k);
    repeat (k) cycle();
  endtask

  task automatic do_load(input logic [6*N-1:0] data, input string why);
    digits_in = data;
    load      = 1'b1;
    $display("load %s: digits=%09h at cycle %0d (frame pos %0d)", why, data, n_m, n_m % FRAME);
    cycle();
    load = 1'b0;
  endtask

  // Advance until the model cycle position within the frame equals pos.
  task automatic wait_pos(input int pos);
    int guard;
    guard = 0;
    while ((n_m % FRAME) != pos && guard <= FRAME) begin
      cycle();
      guard++;
    end
    if (guard > FRAME) check("wait_bound", 64'(0), 64'(1));
  endtask

  initial begin
    logic [6*N-1:0] rd;

    // Reset
    rst = 1'b1;
    run(3);
    rst = 1'b0;

    // Digits 5..0 = F,E,3,2,1,0 at full brightness
    brightness = 2'd3;
    do_load({dg(15,0,0), dg(14,0,0), dg(3,0,0), dg(2,0,0), dg(1,0,0), dg(0,0,0)}, "hex");
    run(2 * FRAME + 20);

    // Digit 2 = 7 with dp, digit 4 blanked
    do_load({dg(15,0,0), dg(14,0,1), dg(3,0,0), dg(7,1,0), dg(1,0,0), dg(0,0,0)}, "dp_blank");
    run(2 * FRAME);

    // Leading-zero suppression
    lz_en = 1'b1;
    do_load({dg(0,0,0), dg(0,0,0), dg(0,0,0), dg(1,0,0), dg(0,0,0), dg(0,0,0)}, "lz_100");
    run(2 * FRAME);
    do_load('0, "lz_zero");
    run(2 * FRAME);
    lz_en = 1'b0;

    // Brightness extremes
    brightness = 2'd0;
    run(FRAME + 10);
    brightness = 2'd1;
    run(FRAME);
    brightness = 2'd3;

    // Load on the edge that ends a frame, on the frame_tick cycle, and mid-frame
    wait_pos(FRAME - 1);
    do_load({dg(9,0,0), dg(8,1,0), dg(7,0,0), dg(6,0,0), dg(5,1,0), dg(4,0,0)}, "boundary");
    wait_pos(0);
    do_load({dg(10,0,0), dg(11,0,0), dg(12,1,0), dg(13,0,0), dg(14,0,0), dg(15,0,0)}, "on_tick");
    wait_pos(FRAME / 2);
    do_load({dg(1,1,0), dg(2,0,0), dg(3,0,0), dg(4,0,0), dg(5,0,0), dg(6,1,0)}, "mid_frame");
    run(2 * FRAME);

    // Randomised traffic
    for (int c = 0; c < 12 * FRAME; c++) begin
      if ($urandom % 64 == 0) begin
        for (int i = 0; i < N; i++) rd[6*i +: 6] = rand_digit();
        do_load(rd, "random");
      end else begin
        if ($urandom % 96 == 0) brightness = BW'($urandom);
        if ($urandom % 256 == 0) lz_en = ~lz_en;
        cycle();
      end
    end

    // Reset in the middle of slot 3
    brightness = 2'd3;
    wait_pos(3 * SLOT_LEN + 10);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(FRAME + 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
